// File: rtl/flash_audio_streamer.sv
// Streams signed 16-bit mono samples out of 32-bit flash words (low half first),
// applying an arithmetic volume shift, with optional looping over the word range.
module flash_audio_streamer #(
  parameter logic [22:0] END_ADDR = 23'h07FFFF,
  parameter bit          LOOP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  vol_shift,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic        aud_valid,
  input  logic        aud_ready,
  output logic [15:0] aud_left,
  output logic [15:0] aud_right,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_SEND_LO,
    S_SEND_HI,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [22:0]        r_ptr;
  logic [31:0]        r_word;
  logic [3:0]         r_vol;
  logic               r_abort;
  logic signed [15:0] w_half;
  logic signed [15:0] w_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_word  <= '0;
      r_vol   <= '0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_abort <= 1'b0;
          if (stop) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
          end else if (start) begin
            r_state <= S_REQ;
            r_ptr   <= '0;
            r_vol   <= vol_shift;
          end
        end
        // A stop seen while a read is in flight is remembered until the data returns.
        S_REQ: begin
          if (stop) r_abort <= 1'b1;
          if (!flash_mem_waitrequest) r_state <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (stop) r_abort <= 1'b1;
          if (flash_mem_readdatavalid) begin
            if (r_abort || stop) begin
              r_state <= S_IDLE;
              r_ptr   <= '0;
              r_abort <= 1'b0;
            end else begin
              r_word  <= flash_mem_readdata;
              r_state <= S_SEND_LO;
            end
          end
        end
        S_SEND_LO: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
          end else if (aud_ready) begin
            r_state <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
          end else if (aud_ready) begin
            if (r_ptr != END_ADDR) begin
              r_ptr   <= r_ptr + 23'd1;
              r_state <= S_REQ;
            end else if (LOOP) begin
              r_ptr   <= '0;
              r_state <= S_REQ;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_half            = (r_state == S_SEND_HI) ? r_word[31:16] : r_word[15:0];
    w_sample          = w_half >>> r_vol;
    flash_mem_read    = (r_state == S_REQ);
    flash_mem_address = flash_mem_read ? r_ptr : '0;
    aud_valid         = (r_state == S_SEND_LO) || (r_state == S_SEND_HI);
    aud_left          = aud_valid ? w_sample : '0;
    aud_right         = aud_left;
    busy              = (r_state != S_IDLE) && (r_state != S_DONE);
    done              = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Bench for flash_audio_streamer: flash slave model, sample/address scoreboard,
// and directed scenarios on a one-shot (END_ADDR=1) and a looping (END_ADDR=2) instance.
module tb_flash_audio_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic        stop  [2];
  logic [3:0]  vol;
  logic        aud_ready;
  logic        rd    [2];
  logic [22:0] addr  [2];
  logic        wreq  [2];
  logic [31:0] rdata [2];
  logic        rdv   [2] = '{1'b0, 1'b0};
  logic        av    [2];
  logic [15:0] al    [2];
  logic [15:0] ar    [2];
  logic        bsy   [2];
  logic        dn    [2];

  logic [31:0] mem [4];
  int          wait_cfg;
  int          rdv_cfg;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_acc  = 0;

  logic [15:0] exp_samp [$];
  logic [22:0] exp_addr [$];

  always #5 clk = ~clk;

  flash_audio_streamer #(.END_ADDR(23'd1), .LOOP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .vol_shift(vol),
    .flash_mem_read(rd[0]), .flash_mem_address(addr[0]),
    .flash_mem_waitrequest(wreq[0]), .flash_mem_readdata(rdata[0]),
    .flash_mem_readdatavalid(rdv[0]), .aud_valid(av[0]), .aud_ready(aud_ready),
    .aud_left(al[0]), .aud_right(ar[0]), .busy(bsy[0]), .done(dn[0]));

  flash_audio_streamer #(.END_ADDR(23'd2), .LOOP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .vol_shift(vol),
    .flash_mem_read(rd[1]), .flash_mem_address(addr[1]),
    .flash_mem_waitrequest(wreq[1]), .flash_mem_readdata(rdata[1]),
    .flash_mem_readdatavalid(rdv[1]), .aud_valid(av[1]), .aud_ready(aud_ready),
    .aud_left(al[1]), .aud_right(ar[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Floor division by 2^v on the signed value: what an arithmetic right shift must yield.
  function automatic logic [15:0] shr(input logic [15:0] x, input int v);
    int s, d, q;
    s = x[15] ? int'({16'h0, x}) - 65536 : int'({16'h0, x});
    d = 1 << v;
    if (s >= 0) q = s / d;
    else q = -((-s + d - 1) / d);
    return q[15:0];
  endfunction

  task automatic push_word(input logic [31:0] w, input int v);
    exp_samp.push_back(shr(w[15:0], v));
    exp_samp.push_back(shr(w[31:16], v));
  endtask

  // Flash slave: waitrequest for wait_cfg cycles per read, data rdv_cfg cycles after accept.
  int         stall [2] = '{0, 0};
  logic       pend  [2] = '{1'b0, 1'b0};
  int         dly   [2];
  logic [1:0] padr  [2];

  always_comb begin
    for (int k = 0; k < 2; k++) wreq[k] = rd[k] && (stall[k] < wait_cfg);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rdv[k]   <= 1'b0;
      rdata[k] <= 32'hDEAD_BEEF;
      if (pend[k]) begin
        if (dly[k] == 1) begin
          rdv[k]   <= 1'b1;
          rdata[k] <= mem[padr[k]];
          pend[k]  <= 1'b0;
        end else begin
          dly[k] <= dly[k] - 1;
        end
      end
      if (rd[k] && !wreq[k]) begin
        stall[k] <= 0;
        if (rdv_cfg <= 1) begin
          rdv[k]   <= 1'b1;
          rdata[k] <= mem[addr[k][1:0]];
        end else begin
          pend[k] <= 1'b1;
          dly[k]  <= rdv_cfg - 1;
          padr[k] <= addr[k][1:0];
        end
      end else if (rd[k]) begin
        stall[k] <= stall[k] + 1;
      end
    end
  end

  // Per-cycle compare against the scoreboard and handshake rules.
  logic        pv    [2] = '{1'b0, 1'b0};
  logic [15:0] pdat  [2];
  logic        pstop [2] = '{1'b0, 1'b0};
  logic        prd   [2] = '{1'b0, 1'b0};
  logic        pwreq [2] = '{1'b0, 1'b0};
  logic [22:0] padd  [2];
  int          hold  [2] = '{0, 0};
  logic        prdy = 1'b0;
  logic        prst = 1'b1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (av[k]) check_eq("mono", 32'(ar[k]), 32'(al[k]));
        if (!prst && pv[k] && !prdy && !pstop[k]) begin
          check_eq("hold_valid", 32'(av[k]), 32'd1);
          check_eq("hold_data", 32'(al[k]), 32'(pdat[k]));
        end
        if (!prst && prd[k] && pwreq[k]) begin
          check_eq("read_held", 32'(rd[k]), 32'd1);
          check_eq("addr_held", 32'(addr[k]), 32'(padd[k]));
        end
        if (av[k] && aud_ready) begin
          check_eq("sample_avail", 32'(exp_samp.size() != 0), 32'd1);
          if (exp_samp.size() != 0) check_eq("sample", 32'(al[k]), 32'(exp_samp.pop_front()));
        end
        if (rd[k] && !wreq[k]) begin
          check_eq("read_len", 32'(hold[k] + 1), 32'(wait_cfg + 1));
          check_eq("addr_avail", 32'(exp_addr.size() != 0), 32'd1);
          if (exp_addr.size() != 0) check_eq("addr", 32'(addr[k]), 32'(exp_addr.pop_front()));
          n_acc++;
          hold[k] = 0;
        end else if (rd[k]) begin
          hold[k]++;
        end else begin
          hold[k] = 0;
        end
      end else begin
        hold[k] = 0;
      end
      pv[k]    = av[k];
      pdat[k]  = al[k];
      pstop[k] = stop[k];
      prd[k]   = rd[k];
      pwreq[k] = wreq[k];
      padd[k]  = addr[k];
    end
    prdy = aud_ready;
    prst = rst;
  end

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  function automatic logic cond_of(input int which, input int k);
    case (which)
      0:       return dn[k];
      1:       return !bsy[k];
      2:       return av[k];
      default: return exp_samp.size() == 0;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int k, input int budget,
                           input string name, output int cycles);
    cycles = 0;
    while (!cond_of(which, k) && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq(name, 32'(cond_of(which, k)), 32'd1);
  endtask

  task automatic check_quiet(input int k, input string name);
    check_eq({name, "_read"}, 32'(rd[k]), 32'd0);
    check_eq({name, "_addr"}, 32'(addr[k]), 32'd0);
    check_eq({name, "_valid"}, 32'(av[k]), 32'd0);
    check_eq({name, "_left"}, 32'(al[k]), 32'd0);
    check_eq({name, "_right"}, 32'(ar[k]), 32'd0);
    check_eq({name, "_busy"}, 32'(bsy[k]), 32'd0);
    check_eq({name, "_done"}, 32'(dn[k]), 32'd0);
  endtask

  task automatic push_basic();
    exp_samp.push_back(16'hABCD);
    exp_samp.push_back(16'h1234);
    exp_samp.push_back(16'h7FFF);
    exp_samp.push_back(16'h8000);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int a0;
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    stop[0]  = 1'b0; stop[1]  = 1'b0;
    vol = 4'd0;
    aud_ready = 1'b1;
    wait_cfg = 0;
    rdv_cfg = 1;
    mem[0] = 32'h1234_ABCD;
    mem[1] = 32'h8000_7FFF;
    mem[2] = 32'hC0DE_0F0F;
    mem[3] = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #1;
    check_quiet(0, "rst0");
    check_quiet(1, "rst1");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic one-shot playback at full rate
    push_basic();
    pulse_start(0);
    check_eq("start_to_read", 32'(rd[0]), 32'd1);
    check_eq("start_addr", 32'(addr[0]), 32'd0);
    wait_cond(0, 0, 100, "basic_done", cyc);
    check_eq("basic_latency", 32'(1 + cyc), 32'd9);
    check_eq("basic_drained", 32'(exp_samp.size()), 32'd0);
    check_eq("basic_read_low", 32'(rd[0]), 32'd0);
    check_eq("basic_valid_low", 32'(av[0]), 32'd0);

    // Stalled slave, restart from DONE
    wait_cfg = 5;
    rdv_cfg = 4;
    a0 = n_acc;
    push_basic();
    pulse_start(0);
    wait_cond(0, 0, 200, "stall_done", cyc);
    check_eq("stall_accepts", 32'(n_acc - a0), 32'd2);
    check_eq("stall_drained", 32'(exp_samp.size()), 32'd0);

    // Random backpressure, vol 3, with a start that must be ignored mid-run
    wait_cfg = 0;
    rdv_cfg = 1;
    vol = 4'd3;
    push_word(mem[0], 3);
    push_word(mem[1], 3);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    pulse_start(0);
    for (int i = 0; i < 300 && !dn[0]; i++) begin
      @(posedge clk); #1;
      aud_ready = 1'($urandom_range(0, 1));
      start[0] = (i == 5);
    end
    start[0] = 1'b0;
    aud_ready = 1'b1;
    check_eq("bp_done", 32'(dn[0]), 32'd1);
    check_eq("bp_drained", 32'(exp_samp.size()), 32'd0);

    // Volume extremes
    vol = 4'd15;
    exp_samp.push_back(16'hFFFF);
    exp_samp.push_back(16'h0000);
    exp_samp.push_back(16'h0000);
    exp_samp.push_back(16'hFFFF);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    pulse_start(0);
    wait_cond(0, 0, 100, "vol15_done", cyc);
    check_eq("vol15_drained", 32'(exp_samp.size()), 32'd0);
    vol = 4'd1;
    exp_samp.push_back(16'hD5E6);
    exp_samp.push_back(16'h091A);
    exp_samp.push_back(16'h3FFF);
    exp_samp.push_back(16'hC000);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    pulse_start(0);
    wait_cond(0, 0, 100, "vol1_done", cyc);
    check_eq("vol1_drained", 32'(exp_samp.size()), 32'd0);

    // Looping instance: addresses 0,1,2,0,1 back to back, then stop on the next request
    vol = 4'd0;
    push_word(mem[0], 0);
    push_word(mem[1], 0);
    push_word(mem[2], 0);
    push_word(mem[0], 0);
    push_word(mem[1], 0);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    exp_addr.push_back(23'd2);
    exp_addr.push_back(23'd0);
    exp_addr.push_back(23'd1);
    pulse_start(1);
    wait_cond(3, 1, 100, "wrap_drain", cyc);
    check_eq("wrap_cycles", 32'(1 + cyc), 32'd21);
    check_eq("wrap_not_done", 32'(dn[1]), 32'd0);
    check_eq("wrap_busy", 32'(bsy[1]), 32'd1);
    exp_addr.push_back(23'd2);
    stop[1] = 1'b1;
    @(posedge clk); #1;
    stop[1] = 1'b0;
    wait_cond(1, 1, 50, "wrap_stop_idle", cyc);
    check_eq("wrap_addr_drained", 32'(exp_addr.size()), 32'd0);
    check_eq("wrap_stop_done", 32'(dn[1]), 32'd0);

    // Stop during a stalled request: completes the read, discards data
    wait_cfg = 5;
    rdv_cfg = 4;
    exp_addr.push_back(23'd0);
    pulse_start(0);
    check_eq("stopreq_stalled", 32'(wreq[0]), 32'd1);
    stop[0] = 1'b1;
    @(posedge clk); #1;
    stop[0] = 1'b0;
    wait_cond(1, 0, 50, "stopreq_idle", cyc);
    check_eq("stopreq_cycles", 32'(2 + cyc), 32'd11);
    check_eq("stopreq_addr_drained", 32'(exp_addr.size()), 32'd0);
    check_eq("stopreq_done", 32'(dn[0]), 32'd0);

    // Stop while presenting the low sample under backpressure
    wait_cfg = 0;
    rdv_cfg = 1;
    aud_ready = 1'b0;
    exp_addr.push_back(23'd0);
    pulse_start(0);
    wait_cond(2, 0, 20, "stoplo_valid", cyc);
    check_eq("stoplo_sample", 32'(al[0]), 32'h0000_ABCD);
    stop[0] = 1'b1;
    @(posedge clk); #1;
    stop[0] = 1'b0;
    check_eq("stoplo_valid_drop", 32'(av[0]), 32'd0);
    check_eq("stoplo_idle", 32'(bsy[0]), 32'd0);
    aud_ready = 1'b1;

    // Reset while waiting for read data; late data must be ignored
    rdv_cfg = 4;
    exp_addr.push_back(23'd0);
    a0 = n_acc;
    pulse_start(0);
    @(posedge clk); #1;
    check_eq("rstw_accepted", 32'(n_acc - a0), 32'd1);
    check_eq("rstw_busy", 32'(bsy[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet(0, "rstw");
    repeat (6) begin
      @(posedge clk); #1;
    end
    check_quiet(0, "rstw_late");
    check_eq("rstw_samples", 32'(exp_samp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
